// File: rtl/frontend_pkg.sv
// ============================================================================
// frontend_pkg : types shared by the fetch requester and the instruction queue
// Rev 1.0
// ============================================================================
`default_nettype none

package frontend_pkg;
    import mem_types_pkg::*;

    localparam logic [IMEM_ADDR_W-1:0] FETCH_RESET_PC = 32'h1eceb000;

    typedef struct packed {
        logic [IMEM_DATA_W-1:0] instr;
        logic [IMEM_ADDR_W-1:0] pc;
    } fetch_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;
endpackage

`default_nettype wire

// File: rtl/mem_types_pkg.sv
// ============================================================================
// mem_types_pkg : instruction-memory request/response field widths
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_types_pkg;
    localparam int IMEM_ADDR_W = 32;
    localparam int IMEM_DATA_W = 32;
    localparam int IMEM_MASK_W = 4;

    localparam logic [IMEM_MASK_W-1:0] IMEM_RMASK_READ = 4'b1111;
    localparam logic [IMEM_MASK_W-1:0] IMEM_RMASK_NONE = 4'b0000;
endpackage

`default_nettype wire

// File: rtl/fetch_requester_if.sv
// ============================================================================
// fetch_requester_if : redirect, instruction-queue and imem signals
// Rev 1.0  (perf ports present only with FETCH_PERF_CNT_EN)
// ============================================================================
`default_nettype none

interface fetch_requester_if;
    import mem_types_pkg::*;
    import frontend_pkg::*;

    logic                   redirect;
    logic [IMEM_ADDR_W-1:0] redirect_pc;
    logic                   iq_full;
    logic                   iq_enq;
    fetch_t                 iq_wdata;
    logic                   iq_flush;
    logic [IMEM_ADDR_W-1:0] imem_addr;
    logic [IMEM_MASK_W-1:0] imem_rmask;
    logic [IMEM_DATA_W-1:0] imem_rdata;
    logic                   imem_resp;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]            perf_fetched;
    logic [31:0]            perf_full_stall;
    logic [31:0]            perf_discarded;

    modport master (
        input  redirect, redirect_pc, iq_full, imem_rdata, imem_resp,
        output iq_enq, iq_wdata, iq_flush, imem_addr, imem_rmask,
        output perf_fetched, perf_full_stall, perf_discarded
    );
    modport slave (
        output redirect, redirect_pc, iq_full, imem_rdata, imem_resp,
        input  iq_enq, iq_wdata, iq_flush, imem_addr, imem_rmask,
        input  perf_fetched, perf_full_stall, perf_discarded
    );
`else
    modport master (
        input  redirect, redirect_pc, iq_full, imem_rdata, imem_resp,
        output iq_enq, iq_wdata, iq_flush, imem_addr, imem_rmask
    );
    modport slave (
        output redirect, redirect_pc, iq_full, imem_rdata, imem_resp,
        input  iq_enq, iq_wdata, iq_flush, imem_addr, imem_rmask
    );
`endif
endinterface

`default_nettype wire

// File: rtl/fetch_requester.sv
// ============================================================================
// fetch_requester : sequential PC fetch, one outstanding imem read, queue push
// Rev 1.0  (optional macro: FETCH_PERF_CNT_EN adds saturating perf counters)
// ============================================================================
`default_nettype none

module fetch_requester
    import mem_types_pkg::*;
    import frontend_pkg::*;
#(
    parameter logic [IMEM_ADDR_W-1:0] RESET_PC = FETCH_RESET_PC,
    parameter logic [IMEM_ADDR_W-1:0] PC_STEP  = 32'd4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    fetch_requester_if.master bus
);

    fetch_state_t           state_q, state_d;
    logic [IMEM_ADDR_W-1:0] pc_q, pc_d;
    logic                   issue;
    logic                   enq;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Outputs are gated by rst so nothing is issued while reset is held.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        issue   = 1'b0;
        enq     = 1'b0;
        if (rst) begin
            case (state_q)
                IDLE: begin
                    if (bus.redirect) begin
                        pc_d = bus.redirect_pc;
                    end else if (!bus.iq_full) begin
                        issue   = 1'b1;
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (bus.imem_resp) begin
                        if (bus.redirect) begin
                            pc_d = bus.redirect_pc;
                        end else begin
                            enq  = 1'b1;
                            pc_d = pc_q + PC_STEP;
                        end
                        state_d = IDLE;
                    end else if (bus.redirect) begin
                        pc_d    = bus.redirect_pc;
                        state_d = DISCARD;
                    end
                end
                DISCARD: begin
                    if (bus.redirect) begin
                        pc_d = bus.redirect_pc;
                    end
                    if (bus.imem_resp) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.imem_addr  = pc_q;
    assign bus.imem_rmask = issue ? IMEM_RMASK_READ : IMEM_RMASK_NONE;
    assign bus.iq_enq     = enq;
    assign bus.iq_wdata   = fetch_t'{instr: bus.imem_rdata, pc: pc_q};
    assign bus.iq_flush   = rst & bus.redirect;

`ifdef FETCH_PERF_CNT_EN
    generate
        if (1'b1) begin : g_perf
            logic [31:0] fetched_q;
            logic [31:0] stall_q;
            logic [31:0] discarded_q;
            logic        stall;
            logic        drop;

            assign stall = rst & (state_q == IDLE) & bus.iq_full;
            assign drop  = rst & bus.imem_resp &
                           ((state_q == DISCARD) || ((state_q == WAIT) && bus.redirect));

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    fetched_q   <= '0;
                    stall_q     <= '0;
                    discarded_q <= '0;
                end else begin
                    if (enq && (fetched_q != '1))     fetched_q   <= fetched_q + 32'd1;
                    if (stall && (stall_q != '1))     stall_q     <= stall_q + 32'd1;
                    if (drop && (discarded_q != '1))  discarded_q <= discarded_q + 32'd1;
                end
            end

            assign bus.perf_fetched    = fetched_q;
            assign bus.perf_full_stall = stall_q;
            assign bus.perf_discarded  = discarded_q;
        end
    endgenerate
`endif

`ifndef SYNTHESIS
    // A response in IDLE is legal only before the first issue after reset,
    // where it may belong to a request that reset abandoned.
    logic late_ok_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            late_ok_q <= 1'b1;
        end else if (issue) begin
            late_ok_q <= 1'b0;
        end
    end

    a_resp_in_idle: assert property (@(posedge clk) disable iff (!rst)
        !(bus.imem_resp && (state_q == IDLE) && !late_ok_q));
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_requester.sv
// ============================================================================
// tb_fetch_requester : directed vector table plus hand-written corner sequences
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_requester;
    import mem_types_pkg::*;
    import frontend_pkg::*;

    localparam logic [31:0] C_RST_PC = 32'h1eceb000;

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    fetch_requester_if bus ();

    fetch_requester dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic [31:0] rpc;
        logic        full;
        logic        resp;
        logic [31:0] rdata;
        logic [3:0]  e_rmask;
        logic        e_enq;
        logic [31:0] e_addr;
        logic        e_flush;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vt[20];

    function automatic vec_t mk(input logic rd, input logic [31:0] rpc, input logic full,
                                input logic resp, input logic [31:0] rdata,
                                input logic [3:0] e_rmask, input logic e_enq,
                                input logic [31:0] e_addr, input logic e_flush,
                                input logic [31:0] e_pc);
        vec_t v;
        v.rd = rd; v.rpc = rpc; v.full = full; v.resp = resp; v.rdata = rdata;
        v.e_rmask = e_rmask; v.e_enq = e_enq; v.e_addr = e_addr;
        v.e_flush = e_flush; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic drive(input logic rd, input logic [31:0] rpc, input logic full,
                         input logic resp, input logic [31:0] rdata);
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.iq_full     = full;
        bus.imem_resp   = resp;
        bus.imem_rdata  = rdata;
    endtask

    // wdata is compared only when an enqueue is expected.
    task automatic check(input string name, input logic [3:0] e_rmask, input logic e_enq,
                         input logic [31:0] e_addr, input logic e_flush,
                         input logic [63:0] e_wdata);
        logic ok;
        ok = (bus.imem_rmask === e_rmask) && (bus.iq_enq === e_enq) &&
             (bus.imem_addr === e_addr) && (bus.iq_flush === e_flush);
        if (e_enq) ok = ok && (bus.iq_wdata === e_wdata);
        n_total++;
        if (ok) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got rmask=%h enq=%b addr=%h flush=%b wdata=%h, want rmask=%h enq=%b addr=%h flush=%b wdata=%h",
                     name, bus.imem_rmask, bus.iq_enq, bus.imem_addr, bus.iq_flush,
                     bus.iq_wdata, e_rmask, e_enq, e_addr, e_flush, e_wdata);
        end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic check_perf(input string name, input logic [31:0] ef,
                              input logic [31:0] es, input logic [31:0] ed);
        n_total++;
        if (bus.perf_fetched === ef && bus.perf_full_stall === es && bus.perf_discarded === ed) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got fetched=%0d stall=%0d discarded=%0d, want %0d %0d %0d",
                     name, bus.perf_fetched, bus.perf_full_stall, bus.perf_discarded, ef, es, ed);
        end
    endtask
`endif

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        //          rd   rpc           full resp rdata          rmask enq addr          flush pc
        vt[0]  = mk(0, 32'h0,        0, 0, 32'h0,        4'hF, 0, 32'h1eceb000, 0, 32'h0);
        vt[1]  = mk(0, 32'h0,        0, 1, 32'hAAAA0001, 4'h0, 1, 32'h1eceb000, 0, 32'h1eceb000);
        vt[2]  = mk(0, 32'h0,        0, 0, 32'h0,        4'hF, 0, 32'h1eceb004, 0, 32'h0);
        vt[3]  = mk(0, 32'h0,        0, 0, 32'h0,        4'h0, 0, 32'h1eceb004, 0, 32'h0);
        vt[4]  = mk(0, 32'h0,        0, 1, 32'h00000002, 4'h0, 1, 32'h1eceb004, 0, 32'h1eceb004);
        vt[5]  = mk(0, 32'h0,        1, 0, 32'h0,        4'h0, 0, 32'h1eceb008, 0, 32'h0);
        vt[6]  = mk(0, 32'h0,        1, 0, 32'h0,        4'h0, 0, 32'h1eceb008, 0, 32'h0);
        vt[7]  = mk(0, 32'h0,        0, 0, 32'h0,        4'hF, 0, 32'h1eceb008, 0, 32'h0);
        vt[8]  = mk(1, 32'h1eceb100, 0, 1, 32'h00000BAD, 4'h0, 0, 32'h1eceb008, 1, 32'h0);
        vt[9]  = mk(0, 32'h0,        0, 0, 32'h0,        4'hF, 0, 32'h1eceb100, 0, 32'h0);
        vt[10] = mk(1, 32'h1eceb200, 0, 0, 32'h0,        4'h0, 0, 32'h1eceb100, 1, 32'h0);
        vt[11] = mk(0, 32'h0,        0, 0, 32'h0,        4'h0, 0, 32'h1eceb200, 0, 32'h0);
        vt[12] = mk(0, 32'h0,        0, 1, 32'h0000DEAD, 4'h0, 0, 32'h1eceb200, 0, 32'h0);
        vt[13] = mk(0, 32'h0,        0, 0, 32'h0,        4'hF, 0, 32'h1eceb200, 0, 32'h0);
        vt[14] = mk(0, 32'h0,        0, 1, 32'h00000003, 4'h0, 1, 32'h1eceb200, 0, 32'h1eceb200);
        vt[15] = mk(1, 32'hFFFFFFFC, 0, 0, 32'h0,        4'h0, 0, 32'h1eceb204, 1, 32'h0);
        vt[16] = mk(0, 32'h0,        0, 0, 32'h0,        4'hF, 0, 32'hFFFFFFFC, 0, 32'h0);
        vt[17] = mk(0, 32'h0,        0, 1, 32'h00000004, 4'h0, 1, 32'hFFFFFFFC, 0, 32'hFFFFFFFC);
        vt[18] = mk(0, 32'h0,        0, 0, 32'h0,        4'hF, 0, 32'h00000000, 0, 32'h0);
        vt[19] = mk(0, 32'h0,        0, 1, 32'h00000005, 4'h0, 1, 32'h00000000, 0, 32'h00000000);

        // Reset state, with a redirect held to confirm flush is masked.
        repeat (2) @(negedge clk);
        drive(1'b1, 32'h12345678, 1'b0, 1'b0, 32'h0);
        #1 check("reset_state", 4'h0, 1'b0, C_RST_PC, 1'b0, 64'h0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 20; i++) begin
            drive(vt[i].rd, vt[i].rpc, vt[i].full, vt[i].resp, vt[i].rdata);
            #1 check($sformatf("vec%0d", i), vt[i].e_rmask, vt[i].e_enq, vt[i].e_addr,
                     vt[i].e_flush, {vt[i].rdata, vt[i].e_pc});
            @(negedge clk);
        end
`ifdef FETCH_PERF_CNT_EN
        check_perf("perf_after_table", 32'd5, 32'd2, 32'd2);
`endif

        // iq_full held for 5 cycles straight out of reset.
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 check($sformatf("full_hold%0d", i), 4'h0, 1'b0, C_RST_PC, 1'b0, 64'h0);
            @(negedge clk);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1 check("full_release_issue", 4'hF, 1'b0, C_RST_PC, 1'b0, 64'h0);
        @(negedge clk);

        // 4-cycle latency fetch, redirected two cycles in.
        #1 check("lat4_wait", 4'h0, 1'b0, C_RST_PC, 1'b0, 64'h0);
        @(negedge clk);
        drive(1'b1, 32'h1eceb100, 1'b0, 1'b0, 32'h0);
        #1 check("lat4_redirect", 4'h0, 1'b0, C_RST_PC, 1'b1, 64'h0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1 check("lat4_discard", 4'h0, 1'b0, 32'h1eceb100, 1'b0, 64'h0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h5A5A5A5A);
        #1 check("lat4_stale_resp", 4'h0, 1'b0, 32'h1eceb100, 1'b0, 64'h0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1 check("lat4_new_issue", 4'hF, 1'b0, 32'h1eceb100, 1'b0, 64'h0);

        // Asynchronous reset mid-WAIT, then a late response.
        @(posedge clk);
        #3 rst = 1'b0;
        #1 check("async_reset", 4'h0, 1'b0, C_RST_PC, 1'b0, 64'h0);
`ifdef FETCH_PERF_CNT_EN
        check_perf("perf_reset", 32'd0, 32'd0, 32'd0);
`endif
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h11111111);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        rst = 1'b1;
        #1 check("post_reset_full", 4'h0, 1'b0, C_RST_PC, 1'b0, 64'h0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h22222222);
        #1 check("late_resp_ignored", 4'h0, 1'b0, C_RST_PC, 1'b0, 64'h0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1 check("restart_issue", 4'hF, 1'b0, C_RST_PC, 1'b0, 64'h0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D);
        #1 check("restart_enq", 4'h0, 1'b1, C_RST_PC, 1'b0, {32'hCAFEF00D, C_RST_PC});
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1 check("restart_next", 4'hF, 1'b0, 32'h1eceb004, 1'b0, 64'h0);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_requester.md
Name: fetch_requester

Overview:
Instruction-memory initiator and producer side of the instruction queue. Generates sequential PCs, issues one outstanding read at a time to imem, and pushes each returned word with its PC into the queue. Throttles on queue-full and handles redirects, dropping stale in-flight responses. Sits between the branch/redirect source and instr_queue in the frontend.

Parameters:
RESET_PC, 32'h1eceb000, PC of the first fetch after reset
PC_STEP, 4, byte increment between sequential fetches

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
redirect  input  1  one-cycle pulse: discard in-flight fetch, restart at redirect_pc
redirect_pc  input  32  redirect target, word-aligned
iq_full  input  1  instruction queue cannot accept an entry
iq_enq  output  1  enqueue strobe to queue
iq_wdata  output  fetch_t  {instruction, pc} for enqueue
iq_flush  output  1  queue flush request, equal to redirect
imem_addr  output  32  fetch address, held stable while a request is outstanding
imem_rmask  output  4  4'b1111 for exactly one cycle = issue read; else 4'b0000
imem_rdata  input  32  read data, valid with imem_resp
imem_resp  input  1  one-cycle response strobe

Behaviour:
- Reset (rst=0, async): state=IDLE, pc_reg=RESET_PC, imem_rmask=0, iq_enq=0, imem_addr=RESET_PC, iq_flush=0.
- imem_addr = pc_reg always; imem_rmask, iq_enq and iq_wdata are combinational from state and inputs.
- States: IDLE (nothing outstanding), WAIT (valid request outstanding), DISCARD (stale request outstanding).
- IDLE, redirect=1: pc_reg<=redirect_pc; no issue this cycle; stay IDLE.
- IDLE, redirect=0, iq_full=0: imem_rmask=4'b1111; go WAIT.
- IDLE, iq_full=1: no issue; stay IDLE.
- WAIT, imem_resp=1, redirect=0: iq_enq=1, iq_wdata={imem_rdata, pc_reg}; pc_reg<=pc_reg+PC_STEP (32-bit wrap); go IDLE. No new request in the response cycle.
- WAIT, imem_resp=1, redirect=1: iq_enq=0 (word dropped); pc_reg<=redirect_pc; go IDLE.
- WAIT, imem_resp=0, redirect=1: pc_reg<=redirect_pc; go DISCARD.
- DISCARD, imem_resp=1: iq_enq=0; go IDLE. A redirect in DISCARD (with or without resp) updates pc_reg only.
- Credit rule: issue only when iq_full=0. This block is the queue's sole producer and has at most one request outstanding, so the slot is guaranteed at response time. iq_enq is never asserted while the queue is physically full.
- Peak throughput: one instruction per (memory latency + 1) cycles.
- imem_resp outside WAIT/DISCARD is a protocol error and is ignored; it asserts under simulation.
- Reset mid-request returns to IDLE. Any late response then arrives in IDLE and is ignored.

Optional Feature:
FETCH_PERF_CNT_EN defined adds three 32-bit outputs, each cleared on reset and saturating:
- perf_fetched: count of iq_enq pulses.
- perf_full_stall: count of IDLE cycles with iq_full=1.
- perf_discarded: count of responses dropped due to redirect.
FETCH_PERF_CNT_EN undefined: the ports and counters do not exist.

Decomposition:
- frontend_pkg: fetch_t (already shared with the queue), the fetch_state_t enum {IDLE, WAIT, DISCARD}, and the RESET_PC default constant.
- mem_types_pkg: imem request/response field widths.
- No sub-module; the FSM and PC register are one block. Perf counters live in a generate region in the same file.

Test Plan:
- Reset release with 1-cycle memory latency and iq_full=0: rmask=F at 0x1eceb000; enq {rdata, 0x1eceb000}; next request at 0x1eceb004 two cycles after the first.
- Hold iq_full=1 for 5 cycles after reset: rmask stays 0 throughout; first request issues the cycle after iq_full falls.
- Redirect to 0x1eceb100 two cycles into a 4-cycle-latency fetch: state goes DISCARD; the response is not enqueued; next request at 0x1eceb100.
- Redirect coincident with imem_resp: iq_enq=0, iq_flush=1; next address is redirect_pc, not pc+4.
- pc_reg=32'hFFFFFFFC, response returns: next imem_addr=32'h00000000.
- Assert rst=0 asynchronously mid-WAIT, then deliver a late response: outputs are reset values immediately; late resp is ignored; fetch restarts at RESET_PC. With FETCH_PERF_CNT_EN, counters read 0.
